// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit adder (W = 4*NIBBLES) that reuses one 4-bit
// ripple_adder over NIBBLES cycles, least-significant slice first.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand handshake (a, b, cin taken in IDLE only)
//   a, b, cin             operands and carry-in
//   out_valid / out_ready result handshake (held in DONE until accepted)
//   sum, cout             registered result, held until the next completion
//   busy                  an accepted operation has not yet been handed off

// 4-bit ripple-carry adder used as the per-slice arithmetic unit.
module ripple_adder (
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       Z,
    output logic [3:0] S,
    output logic       Co
);
    logic c;

    always_comb begin
        c = Z;
        S = '0;
        for (int i = 0; i < 4; i++) begin
            S[i] = X[i] ^ Y[i] ^ c;
            c    = (X[i] & Y[i]) | (c & (X[i] ^ Y[i]));
        end
        Co = c;
    end
endmodule

module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   busy
);
    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned SH_W  = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_lat;
    logic [W-1:0]     b_lat;
    logic             cin_lat;
    logic             carry;
    logic [W-1:0]     partial;

    logic             accept;
    logic             last;
    logic [SH_W-1:0]  sh;
    logic [3:0]       slice_x;
    logic [3:0]       slice_y;
    logic             slice_z;
    logic [3:0]       slice_s;
    logic             slice_co;
    logic [W-1:0]     partial_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && in_valid;
    assign last   = (idx == LAST_IDX);

    // Slice select: bit offset of the current nibble
    assign sh      = {idx, 2'b00};
    assign slice_x = 4'(a_lat >> sh);
    assign slice_y = 4'(b_lat >> sh);
    assign slice_z = (idx == '0) ? cin_lat : carry;

    ripple_adder u_ripple (
        .X  (slice_x),
        .Y  (slice_y),
        .Z  (slice_z),
        .S  (slice_s),
        .Co (slice_co)
    );

    // Partial result with the current slice merged in, so the final load
    // includes the top nibble computed in the same cycle.
    assign partial_nxt = (partial & ~(W'(4'hF) << sh)) | (W'(slice_s) << sh);

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            a_lat   <= '0;
            b_lat   <= '0;
            cin_lat <= 1'b0;
            carry   <= 1'b0;
            partial <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            a_lat   <= a;
            b_lat   <= b;
            cin_lat <= cin;
            idx     <= '0;
        end else if (state == RUN) begin
            partial <= partial_nxt;
            carry   <= slice_co;
            idx     <= idx + IDX_W'(1);
            if (last) begin
                sum  <= partial_nxt;
                cout <= slice_co;
            end
        end
    end

    // Handshake flags decoded directly from the state register
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: table-driven vectors on a
// 4-nibble instance, hand-written handshake/reset sequences, and an
// exhaustive sweep on a 1-nibble instance.
module tb_nibble_serial_adder;
    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [W-1:0] a, b, sum;

    logic         in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
    logic [3:0]   a1, b1, sum1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, accept, and wait (bounded) for out_valid.
    task automatic start_wait(input logic [15:0] ta, input logic [15:0] tb,
                              input logic tc, input bit scramble);
        int cyc;
        bit busy_ok;
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        check("in_ready_pre_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        cyc      = 0;
        busy_ok  = 1'b1;
        while (!out_valid && cyc < 20) begin
            if (!busy) busy_ok = 1'b0;
            if (scramble) begin
                a   = 16'($urandom);
                b   = 16'($urandom);
                cin = ~cin;
            end
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(N));
        check("busy_in_run", 32'(busy_ok), 32'd1);
    endtask

    task automatic release_out();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_after_release", 32'({busy, in_ready, out_valid}), 32'b010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
        vecs[8] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
        vecs[9] = '{16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick();
        tick();
        check("reset_flags", 32'({out_valid, busy, in_ready}), 32'b001);
        check("reset_result", 32'({cout, sum}), 32'd0);
        check("reset_flags_n1", 32'({out_valid1, busy1, in_ready1}), 32'b001);
        rst_n = 1'b1;
        tick();

        // Table vectors; odd entries scramble inputs during RUN
        for (int i = 0; i < 10; i++) begin
            start_wait(vecs[i].a, vecs[i].b, vecs[i].cin, (i % 2) == 1);
            check($sformatf("vec%0d_result", i), 32'({cout, sum}), 32'({vecs[i].co, vecs[i].s}));
            check($sformatf("vec%0d_busy_done", i), 32'({busy, in_ready}), 32'b10);
            release_out();
            check($sformatf("vec%0d_hold_idle", i), 32'({cout, sum}), 32'({vecs[i].co, vecs[i].s}));
        end

        // Back-pressure in DONE while new operands are offered
        begin
            bit hold_ok;
            start_wait(16'h1234, 16'h4321, 1'b1, 1'b0);
            hold_ok = 1'b1;
            for (int k = 0; k < 5; k++) begin
                in_valid = 1'b1;
                a = 16'hFFFF - 16'(k); b = 16'h0F0F; cin = 1'b1;
                tick();
                if ({out_valid, in_ready, busy, cout, sum} !== {3'b101, 1'b0, 16'h5556}) hold_ok = 1'b0;
            end
            check("done_hold_stable", 32'(hold_ok), 32'd1);
            release_out();
            check("done_hold_result", 32'({cout, sum}), 32'h5556);
            tick();
            check("new_ops_not_taken", 32'({busy, in_ready}), 32'b01);
        end

        // Async reset in the second RUN cycle, then a clean operation
        begin
            bit no_pulse;
            a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            #2 rst_n = 1'b0;
            #1;
            check("async_rst_flags", 32'({out_valid, in_ready, busy}), 32'b010);
            check("async_rst_result", 32'({cout, sum}), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            no_pulse = 1'b1;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (out_valid) no_pulse = 1'b0;
            end
            check("no_out_valid_after_rst", 32'(no_pulse), 32'd1);
            start_wait(16'h00FF, 16'h0001, 1'b0, 1'b0);
            check("post_rst_result", 32'({cout, sum}), 32'h0100);
            release_out();
        end

        // Exhaustive NIBBLES=1 sweep
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            logic       ov0;
            int         e;
            v = 9'(i);
            {a1, b1, cin1} = v;
            e = int'(a1) + int'(b1) + int'(cin1);
            in_valid1 = 1'b1;
            tick();
            in_valid1 = 1'b0;
            ov0 = out_valid1;
            tick();
            check($sformatf("n1_latency_%0d", i), 32'({ov0, out_valid1}), 32'b01);
            check($sformatf("n1_sum_%0d", i), 32'({cout1, sum1}), 32'(e));
            out_ready1 = 1'b1;
            tick();
            out_ready1 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
